pipeline_stall_ctrl: RTL and testbench

Hazard and multi-cycle sequencing controller for the 5-stage RISC pipeline. It detects load-use hazards between ID and EX and inserts one bubble. It issues multiply and divide operations to an iterative mul/div unit and freezes IF/ID/EX until that unit reports completion. It drives the PC, IF/ID, ID/EX and EX/MEM register enables, and keeps a saturating stall counter and a sticky timeout flag.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 27 ++
 rtl/pipeline_stall_ctrl_hazard_detect.sv | 31 +++
 rtl/pipeline_stall_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl_pkg
// Shared definitions for the 5-stage RISC pipeline control slice:
//   - ALU control codes driven by the EX stage decoder
//   - stall-controller FSM state encoding
//   - helper that classifies an ALU control code as a mul/div operation
// ---------------------------------------------------------------------------
package pipeline_stall_ctrl_pkg;

   localparam logic [3:0] ALUCTRL_AND = 4'b0000;
   localparam logic [3:0] ALUCTRL_OR  = 4'b0001;
   localparam logic [3:0] ALUCTRL_ADD = 4'b0010;
   localparam logic [3:0] ALUCTRL_MUL = 4'b0011;
   localparam logic [3:0] ALUCTRL_DIV = 4'b0100;
   localparam logic [3:0] ALUCTRL_SUB = 4'b0110;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_MD_WAIT = 1'b1
   } stall_state_t;

   // True when the code selects the iterative mul/div unit.
   function automatic logic is_md_op(input logic [3:0] aluctrl);
      return (aluctrl == ALUCTRL_MUL) || (aluctrl == ALUCTRL_DIV);
   endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use hazard detector between ID and EX.
// Ports:
//   id_valid, id_rs, id_rt, id_uses_rt : instruction currently in ID
//   ex_valid, ex_memread, ex_write_reg : instruction currently in EX
//   lu_haz                             : ID consumes a register the EX load
//                                        has not produced yet
// ---------------------------------------------------------------------------
module hazard_detect (
   input  logic       id_valid,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic       ex_valid,
   input  logic       ex_memread,
   input  logic [4:0] ex_write_reg,
   output logic       lu_haz
);

   logic w_rs_match;
   logic w_rt_match;

   assign w_rs_match = (ex_write_reg == id_rs);
   assign w_rt_match = id_uses_rt && (ex_write_reg == id_rt);

   // r0 is hardwired to zero, so a load targeting it never creates a hazard.
   assign lu_haz = id_valid && ex_valid && ex_memread &&
                   (ex_write_reg != 5'd0) && (w_rs_match || w_rt_match);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl
// Hazard and multi-cycle sequencing controller for the 5-stage pipeline.
// Inserts one bubble on a load-use hazard, issues mul/div operations and
// freezes IF/ID/EX until the unit reports done (or a timeout forces release).
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   id_* / ex_*         : ID and EX stage instruction information
//   md_done             : mul/div result valid
//   md_start, md_op     : issue pulse and operation (0 mul, 1 div)
//   pc_write, ifid_write: PC and IF/ID register enables
//   idex_bubble         : zero control bits entering ID/EX
//   ex_hold             : hold ID/EX register
//   exmem_bubble        : zero control bits entering EX/MEM
//   md_timeout          : sticky flag, set on a timeout release
//   stall_count         : saturating count of cycles with pc_write=0
// ---------------------------------------------------------------------------
module pipeline_stall_ctrl
   import pipeline_stall_ctrl_pkg::*;
#(
   parameter int MD_TIMEOUT = 40,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_valid,
   input  logic             ex_memread,
   input  logic [4:0]       ex_write_reg,
   input  logic [3:0]       ex_aluctrl,
   input  logic             md_done,
   output logic             md_start,
   output logic             md_op,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             idex_bubble,
   output logic             ex_hold,
   output logic             exmem_bubble,
   output logic             md_timeout,
   output logic [CNT_W-1:0] stall_count
);

   localparam int                WAIT_W    = $clog2(MD_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);

   stall_state_t      r_state;
   stall_state_t      w_state_next;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic [WAIT_W-1:0] w_wait_cnt_next;
   logic              r_md_timeout;
   logic              w_md_timeout_next;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic              w_md_req;
   logic              w_lu_haz;

   hazard_detect u_hazard_detect (
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rt   (id_uses_rt),
      .ex_valid     (ex_valid),
      .ex_memread   (ex_memread),
      .ex_write_reg (ex_write_reg),
      .lu_haz       (w_lu_haz)
   );

   assign w_md_req = ex_valid && is_md_op(ex_aluctrl);

   // Mealy output decode and next-state logic. Outputs default to the
   // free-running pattern, which is also the forced pattern during reset.
   always_comb begin
      md_start          = 1'b0;
      md_op             = 1'b0;
      pc_write          = 1'b1;
      ifid_write        = 1'b1;
      idex_bubble       = 1'b0;
      ex_hold           = 1'b0;
      exmem_bubble      = 1'b0;
      w_state_next      = r_state;
      w_wait_cnt_next   = r_wait_cnt;
      w_md_timeout_next = r_md_timeout;

      if (!reset) begin
         case (r_state)
            ST_RUN: begin
               if (w_md_req) begin
                  md_start        = 1'b1;
                  md_op           = (ex_aluctrl == ALUCTRL_DIV);
                  pc_write        = 1'b0;
                  ifid_write      = 1'b0;
                  ex_hold         = 1'b1;
                  exmem_bubble    = 1'b1;
                  w_state_next    = ST_MD_WAIT;
                  w_wait_cnt_next = '0;
               end else if (w_lu_haz) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
               end
            end
            ST_MD_WAIT: begin
               // Release cycle: the MD instruction leaves EX on this edge,
               // so no re-issue even though EX still shows a MUL/DIV code.
               if (md_done || (r_wait_cnt == WAIT_LAST)) begin
                  w_state_next    = ST_RUN;
                  w_wait_cnt_next = '0;
                  if (!md_done) begin
                     w_md_timeout_next = 1'b1;
                  end
               end else begin
                  pc_write        = 1'b0;
                  ifid_write      = 1'b0;
                  ex_hold         = 1'b1;
                  exmem_bubble    = 1'b1;
                  w_wait_cnt_next = r_wait_cnt + 1'b1;
               end
            end
            default: begin
               w_state_next = ST_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_RUN;
         r_wait_cnt   <= '0;
         r_md_timeout <= 1'b0;
         r_stall_cnt  <= '0;
      end else begin
         r_state      <= w_state_next;
         r_wait_cnt   <= w_wait_cnt_next;
         r_md_timeout <= w_md_timeout_next;
         if (!pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
      end
   end

   assign md_timeout  = r_md_timeout;
   assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
// Directed-vector bench for pipeline_stall_ctrl. Inputs change 1 time unit
// after the rising edge; outputs are compared 1 time unit later.
// Control vector order: {md_start, md_op, pc_write, ifid_write,
//                        idex_bubble, ex_hold, exmem_bubble}
// ---------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;

   localparam logic [6:0] CTL_FREE  = 7'b0011000;
   localparam logic [6:0] CTL_LU    = 7'b0000100;
   localparam logic [6:0] CTL_MUL   = 7'b1000011;
   localparam logic [6:0] CTL_DIV   = 7'b1100011;
   localparam logic [6:0] CTL_WAIT  = 7'b0000011;
   localparam logic [3:0] OP_ADD    = 4'b0010;
   localparam logic [3:0] OP_MUL    = 4'b0011;
   localparam logic [3:0] OP_DIV    = 4'b0100;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_uses_rt;
   logic        ex_valid;
   logic        ex_memread;
   logic [4:0]  ex_write_reg;
   logic [3:0]  ex_aluctrl;
   logic        md_done;
   logic        md_start;
   logic        md_op;
   logic        pc_write;
   logic        ifid_write;
   logic        idex_bubble;
   logic        ex_hold;
   logic        exmem_bubble;
   logic        md_timeout;
   logic [15:0] stall_count;
   logic [6:0]  ctl;

   int n_checks = 0;
   int n_errors = 0;

   assign ctl = {md_start, md_op, pc_write, ifid_write, idex_bubble, ex_hold, exmem_bubble};

   always #5 clk = ~clk;

   pipeline_stall_ctrl #(.MD_TIMEOUT(40), .CNT_W(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rt   (id_uses_rt),
      .ex_valid     (ex_valid),
      .ex_memread   (ex_memread),
      .ex_write_reg (ex_write_reg),
      .ex_aluctrl   (ex_aluctrl),
      .md_done      (md_done),
      .md_start     (md_start),
      .md_op        (md_op),
      .pc_write     (pc_write),
      .ifid_write   (ifid_write),
      .idex_bubble  (idex_bubble),
      .ex_hold      (ex_hold),
      .exmem_bubble (exmem_bubble),
      .md_timeout   (md_timeout),
      .stall_count  (stall_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
      ex_valid = 0; ex_memread = 0; ex_write_reg = 0; ex_aluctrl = OP_ADD;
      md_done = 0;
   endtask

   task automatic test_reset();
      // Reset with a MUL in EX: outputs must still show the forced pattern.
      reset = 1; idle_inputs();
      ex_valid = 1; ex_aluctrl = OP_MUL;
      #1;
      n_checks++;
      if (ctl !== CTL_FREE) begin n_errors++; $display("FAIL reset_forced ctl got %b exp %b", ctl, CTL_FREE); end
      step(); step();
      n_checks++;
      if (stall_count !== 16'd0) begin n_errors++; $display("FAIL reset_stall_count got %0d exp 0", stall_count); end
      n_checks++;
      if (md_timeout !== 1'b0) begin n_errors++; $display("FAIL reset_md_timeout got %b exp 0", md_timeout); end
      idle_inputs(); reset = 0;
      #1;
      n_checks++;
      if (ctl !== CTL_FREE) begin n_errors++; $display("FAIL reset_idle ctl got %b exp %b", ctl, CTL_FREE); end
      $display("test_reset done: stall_count=%0d", stall_count);
   endtask

   task automatic test_load_use();
      step();
      id_valid = 1; id_rs = 5'd3; id_rt = 5'd7;
      ex_valid = 1; ex_memread = 1; ex_write_reg = 5'd3;
      #1;
      n_checks++;
      if (ctl !== CTL_LU) begin n_errors++; $display("FAIL lu_stall ctl got %b exp %b", ctl, CTL_LU); end
      step();
      // Bubble now in EX, dependent instruction still in ID.
      ex_valid = 0; ex_memread = 0; ex_write_reg = 0;
      #1;
      n_checks++;
      if (ctl !== CTL_FREE) begin n_errors++; $display("FAIL lu_after ctl got %b exp %b", ctl, CTL_FREE); end
      n_checks++;
      if (stall_count !== 16'd1) begin n_errors++; $display("FAIL lu_stall_count got %0d exp 1", stall_count); end
      $display("test_load_use done: stall_count=%0d", stall_count);
   endtask

   task automatic test_no_hazard();
      step();
      id_valid = 1; id_rs = 5'd0; id_rt = 5'd9; id_uses_rt = 1;
      ex_valid = 1; ex_memread = 1; ex_write_reg = 5'd0;
      #1;
      n_checks++;
      if (ctl !== CTL_FREE) begin n_errors++; $display("FAIL lu_r0 ctl got %b exp %b", ctl, CTL_FREE); end
      id_rs = 5'd1; id_rt = 5'd5; id_uses_rt = 0; ex_write_reg = 5'd5;
      #1;
      n_checks++;
      if (ctl !== CTL_FREE) begin n_errors++; $display("FAIL lu_rt_unused ctl got %b exp %b", ctl, CTL_FREE); end
      id_uses_rt = 1;
      #1;
      n_checks++;
      if (ctl !== CTL_LU) begin n_errors++; $display("FAIL lu_rt_used ctl got %b exp %b", ctl, CTL_LU); end
      step();
      idle_inputs();
      #1;
      n_checks++;
      if (stall_count !== 16'd2) begin n_errors++; $display("FAIL nohaz_stall_count got %0d exp 2", stall_count); end
      $display("test_no_hazard done: stall_count=%0d", stall_count);
   endtask

   task automatic test_mul();
      step();
      ex_valid = 1; ex_aluctrl = OP_MUL;
      #1;
      n_checks++;
      if (ctl !== CTL_MUL) begin n_errors++; $display("FAIL mul_issue ctl got %b exp %b", ctl, CTL_MUL); end
      for (int k = 1; k <= 4; k++) begin
         step();
         // A load-use pattern during the freeze must not add a bubble.
         if (k == 2) begin
            id_valid = 1; id_rs = 5'd4; ex_memread = 1; ex_write_reg = 5'd4;
         end else begin
            id_valid = 0; ex_memread = 0; ex_write_reg = 0;
         end
         #1;
         n_checks++;
         if (ctl !== CTL_WAIT) begin n_errors++; $display("FAIL mul_wait%0d ctl got %b exp %b", k, ctl, CTL_WAIT); end
      end
      step();
      md_done = 1;
      #1;
      n_checks++;
      if (ctl !== CTL_FREE) begin n_errors++; $display("FAIL mul_release ctl got %b exp %b", ctl, CTL_FREE); end
      step();
      idle_inputs();
      #1;
      n_checks++;
      if (stall_count !== 16'd7) begin n_errors++; $display("FAIL mul_stall_count got %0d exp 7", stall_count); end
      n_checks++;
      if (md_timeout !== 1'b0) begin n_errors++; $display("FAIL mul_md_timeout got %b exp 0", md_timeout); end
      $display("test_mul done: stall_count=%0d", stall_count);
   endtask

   task automatic test_div_timeout();
      step();
      ex_valid = 1; ex_aluctrl = OP_DIV;
      #1;
      n_checks++;
      if (ctl !== CTL_DIV) begin n_errors++; $display("FAIL div_issue ctl got %b exp %b", ctl, CTL_DIV); end
      for (int k = 1; k <= 39; k++) begin
         step();
         n_checks++;
         if (ctl !== CTL_WAIT) begin n_errors++; $display("FAIL div_wait%0d ctl got %b exp %b", k, ctl, CTL_WAIT); end
      end
      n_checks++;
      if (md_timeout !== 1'b0) begin n_errors++; $display("FAIL div_timeout_early got %b exp 0", md_timeout); end
      step();
      // 40th MD_WAIT cycle: forced release.
      n_checks++;
      if (ctl !== CTL_FREE) begin n_errors++; $display("FAIL div_release ctl got %b exp %b", ctl, CTL_FREE); end
      step();
      idle_inputs();
      #1;
      n_checks++;
      if (md_timeout !== 1'b1) begin n_errors++; $display("FAIL div_md_timeout got %b exp 1", md_timeout); end
      n_checks++;
      if (stall_count !== 16'd47) begin n_errors++; $display("FAIL div_stall_count got %0d exp 47", stall_count); end
      // Stray md_done in RUN is ignored; flag stays sticky.
      md_done = 1;
      #1;
      n_checks++;
      if (ctl !== CTL_FREE) begin n_errors++; $display("FAIL div_stray_done ctl got %b exp %b", ctl, CTL_FREE); end
      step(); step();
      md_done = 0;
      #1;
      n_checks++;
      if (md_timeout !== 1'b1) begin n_errors++; $display("FAIL div_md_timeout_sticky got %b exp 1", md_timeout); end
      $display("test_div_timeout done: stall_count=%0d md_timeout=%b", stall_count, md_timeout);
   endtask

   task automatic test_reset_mid_wait();
      step();
      ex_valid = 1; ex_aluctrl = OP_MUL;
      step(); step(); step();
      // Third MD_WAIT cycle.
      #1;
      n_checks++;
      if (ctl !== CTL_WAIT) begin n_errors++; $display("FAIL rst_wait ctl got %b exp %b", ctl, CTL_WAIT); end
      reset = 1;
      #1;
      n_checks++;
      if (ctl !== CTL_FREE) begin n_errors++; $display("FAIL rst_forced ctl got %b exp %b", ctl, CTL_FREE); end
      step();
      reset = 0; idle_inputs();
      #1;
      n_checks++;
      if (stall_count !== 16'd0) begin n_errors++; $display("FAIL rst_stall_count got %0d exp 0", stall_count); end
      n_checks++;
      if (md_timeout !== 1'b0) begin n_errors++; $display("FAIL rst_md_timeout got %b exp 0", md_timeout); end
      step();
      md_done = 1;
      #1;
      n_checks++;
      if (ctl !== CTL_FREE) begin n_errors++; $display("FAIL rst_late_done ctl got %b exp %b", ctl, CTL_FREE); end
      step();
      md_done = 0;
      #1;
      n_checks++;
      if (stall_count !== 16'd0) begin n_errors++; $display("FAIL rst_late_count got %0d exp 0", stall_count); end
      $display("test_reset_mid_wait done: stall_count=%0d", stall_count);
   endtask

   task automatic test_saturation();
      step();
      id_valid = 1; id_rs = 5'd8;
      ex_valid = 1; ex_memread = 1; ex_write_reg = 5'd8;
      repeat (65534) @(posedge clk);
      #1;
      n_checks++;
      if (stall_count !== 16'hFFFE) begin n_errors++; $display("FAIL sat_before got %h exp fffe", stall_count); end
      repeat (20) @(posedge clk);
      #1;
      n_checks++;
      if (stall_count !== 16'hFFFF) begin n_errors++; $display("FAIL sat_hold got %h exp ffff", stall_count); end
      n_checks++;
      if (ctl !== CTL_LU) begin n_errors++; $display("FAIL sat_ctl got %b exp %b", ctl, CTL_LU); end
      idle_inputs();
      $display("test_saturation done: stall_count=%h", stall_count);
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_hazard();
      test_mul();
      test_div_timeout();
      test_reset_mid_wait();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
